// File: rtl/cnu_serial_minsum_pkg.sv
// Shared constants, FSM state type and message conversion helpers for the serial
// min-sum check-node unit.
package cnu_serial_minsum_pkg;

  localparam int W    = 10;
  localparam int WABS = W - 1;
  localparam int DC   = 6;
  localparam int IDXW = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // The most negative code has no positive counterpart, so it clips to the largest magnitude.
  function automatic logic [WABS-1:0] sat_abs(input logic [W-1:0] x);
    logic [W-1:0] neg;
    neg = -x;
    if (x == {1'b1, {WABS{1'b0}}})
      return {WABS{1'b1}};
    return x[W-1] ? neg[WABS-1:0] : x[WABS-1:0];
  endfunction

  function automatic logic [W-1:0] to_twos(input logic s, input logic [WABS-1:0] m);
    logic [W-1:0] p;
    p = {1'b0, m};
    return s ? -p : p;
  endfunction

endpackage

// File: rtl/cnu_serial_minsum_if.sv
// Message stream bundle: variable-to-check input and check-to-variable output,
// each with its own valid/ready pair.
interface cnu_serial_minsum_if;
  import cnu_serial_minsum_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/cnu_serial_minsum_normaliser.sv
// Magnitude normaliser: y = floor((m + floor(m/2)) / 2), i.e. 0.75 scaling rounded down.
// Purely combinational; the sum never exceeds MW+1 bits, so the result fits in MW bits.
module cnu_serial_minsum_normaliser #(
  parameter int MW = 9
) (
  input  logic [MW-1:0] m,
  output logic [MW-1:0] y
);

  assign y = MW'(({1'b0, m} + {2'b00, m[MW-1:1]}) >> 1);

endmodule

// File: rtl/cnu_serial_minsum.sv
// Serial normalised min-sum check node: collects DC messages, then emits DC replies in input order.
// First reply one cycle after the last accept; replies hold while out_ready is low, input is closed during emit.
module cnu_serial_minsum
  import cnu_serial_minsum_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cnu_serial_minsum_if.slave   io
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] cnt;
  logic [WABS-1:0] min1;
  logic [WABS-1:0] min2;
  logic [IDXW-1:0] min1_idx;
  logic            parity;
  logic [DC-1:0]   sign_store;

  logic            emit;
  logic            in_fire;
  logic            out_fire;
  logic            last;
  logic [WABS-1:0] in_mag;
  logic            in_sign;
  logic [WABS-1:0] norm_min1;
  logic [WABS-1:0] norm_min2;
  logic [WABS-1:0] emit_mag;
  logic            emit_sign;

  assign emit     = (state == EMIT);
  assign in_fire  = !emit && io.in_valid;
  assign out_fire = emit && io.out_ready;
  assign last     = (cnt == LAST);
  assign in_mag   = sat_abs(io.in_data);
  assign in_sign  = io.in_data[W-1];

  cnu_serial_minsum_normaliser #(.MW(WABS)) u_norm_min1 (
    .m (min1),
    .y (norm_min1)
  );

  cnu_serial_minsum_normaliser #(.MW(WABS)) u_norm_min2 (
    .m (min2),
    .y (norm_min2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.out_data  = '0;
    io.out_idx   = '0;
    emit_mag     = norm_min1;
    emit_sign    = 1'b0;
    case (state)
      COLLECT: begin
        io.in_ready = 1'b1;
        if (in_fire && last)
          state_nxt = EMIT;
      end
      EMIT: begin
        // The element that supplied min1 must see the best of the others, i.e. min2.
        emit_mag     = (cnt == min1_idx) ? norm_min2 : norm_min1;
        emit_sign    = parity ^ sign_store[cnt];
        io.out_valid = 1'b1;
        io.out_idx   = cnt;
        io.out_data  = to_twos(emit_sign, emit_mag);
        if (out_fire && last)
          state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      min1       <= '1;
      min2       <= '1;
      min1_idx   <= '0;
      parity     <= 1'b0;
      sign_store <= '0;
    end else if (in_fire) begin
      // Strict compares keep the first occurrence as min1; a tie then lands in min2.
      if (in_mag < min1) begin
        min2     <= min1;
        min1     <= in_mag;
        min1_idx <= cnt;
      end else if (in_mag < min2) begin
        min2 <= in_mag;
      end
      parity          <= parity ^ in_sign;
      sign_store[cnt] <= in_sign;
      cnt             <= last ? '0 : cnt + 1'b1;
    end else if (out_fire) begin
      if (last) begin
        cnt        <= '0;
        min1       <= '1;
        min2       <= '1;
        min1_idx   <= '0;
        parity     <= 1'b0;
        sign_store <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// Directed and randomised frames through the serial check node, checked against a queue of expected replies.
module tb_cnu_serial_minsum;
  import cnu_serial_minsum_pkg::*;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [IDXW-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cnu_serial_minsum_if bus();

  cnu_serial_minsum dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int   compared = 0;
  int   errs     = 0;
  exp_t q[$];
  int   acc_cnt  = 0;
  bit   chk_valid_next = 1'b0;
  bit   stalled_prev   = 1'b0;
  logic [W-1:0]    held_data;
  logic [IDXW-1:0] held_idx;

  int basic_v[6] = '{5, -3, 8, -2, 7, 4};
  int basic_e[6] = '{1, -1, 1, -2, 1, 1};
  int tie_v[6]   = '{4, 4, 4, 4, 4, 4};
  int tie_e[6]   = '{3, 3, 3, 3, 3, 3};
  int sat_v[6]   = '{-512, -512, -512, -512, -512, -512};
  int sat_e[6]   = '{-383, -383, -383, -383, -383, -383};
  int zero_v[6]  = '{0, -6, 9, 10, 11, 12};
  int zero_e[6]  = '{-4, 0, 0, 0, 0, 0};

  // Reference: min1 = first smallest, the reply for element j uses the smallest of the other five.
  function automatic void model(input int vals[6], output int exp_o[6]);
    int mag[6];
    int sgn[6];
    int m1, i1, m2, par, mm, n, x;
    logic [W-1:0] v;
    m1 = 1 << 30; i1 = 0; m2 = 1 << 30; par = 0;
    for (int i = 0; i < 6; i++) begin
      v      = 10'(vals[i]);
      x      = $signed(v);
      sgn[i] = int'(v[W-1]);
      mag[i] = (x < 0) ? -x : x;
      if (mag[i] > 511) mag[i] = 511;
      par = par ^ sgn[i];
    end
    for (int i = 0; i < 6; i++)
      if (mag[i] < m1) begin m1 = mag[i]; i1 = i; end
    for (int i = 0; i < 6; i++)
      if (i != i1 && mag[i] < m2) m2 = mag[i];
    for (int j = 0; j < 6; j++) begin
      mm = (j == i1) ? m2 : m1;
      n  = (mm + mm / 2) / 2;
      exp_o[j] = ((par ^ sgn[j]) != 0) ? -n : n;
    end
  endfunction

  task automatic cycle(output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (chk_valid_next) begin
      compared++;
      assert (bus.out_valid === 1'b1) else begin
        errs++; $error("FAIL latency out_valid=%b expected 1", bus.out_valid);
      end
      chk_valid_next = 1'b0;
    end
    if (stalled_prev) begin
      compared++;
      assert (bus.out_data === held_data && bus.out_idx === held_idx) else begin
        errs++; $error("FAIL stall_hold data=%h idx=%0d expected data=%h idx=%0d",
                       bus.out_data, bus.out_idx, held_data, held_idx);
      end
    end
    if (bus.out_valid === 1'b1) begin
      compared++;
      assert (bus.in_ready === 1'b0) else begin
        errs++; $error("FAIL in_ready_during_emit in_ready=%b expected 0", bus.in_ready);
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      compared++;
      assert (q.size() != 0) else begin
        errs++; $error("FAIL unexpected_output data=%h idx=%0d expected none", bus.out_data, bus.out_idx);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        compared++;
        assert (bus.out_data === e.data) else begin
          errs++; $error("FAIL out_data got=%h expected=%h (idx %0d)", bus.out_data, e.data, e.idx);
        end
        compared++;
        assert (bus.out_idx === e.idx) else begin
          errs++; $error("FAIL out_idx got=%0d expected=%0d", bus.out_idx, e.idx);
        end
      end
    end
    stalled_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    held_data    = bus.out_data;
    held_idx     = bus.out_idx;
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      acc = 1'b1;
      acc_cnt++;
      if (acc_cnt == DC) begin
        acc_cnt        = 0;
        chk_valid_next = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_inputs(input int vals[6], input int n, input bit gaps);
    bit acc;
    int waits;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) cycle(acc);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(vals[k]);
      acc   = 1'b0;
      waits = 0;
      while (!acc && waits < 20) begin
        cycle(acc);
        waits++;
      end
      if (!acc) begin
        compared++;
        errs++;
        $error("FAIL accept_timeout input %0d not accepted, expected accept", k);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int vals[6], input int exp_v[6], input bit gaps);
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      e.data = 10'(exp_v[k]);
      e.idx  = 3'(k);
      q.push_back(e);
    end
    send_inputs(vals, 6, gaps);
  endtask

  task automatic drain(input int stall_at, input int stop_left);
    int n = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit dummy;
    while (q.size() > stop_left && n < 200) begin
      if (stall_at >= 0 && !stalled && bus.out_valid === 1'b1 && int'(bus.out_idx) == stall_at) begin
        stall_left = 3;
        stalled    = 1'b1;
      end
      bus.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      cycle(dummy);
      n++;
    end
    bus.out_ready = 1'b1;
    compared++;
    assert (q.size() == stop_left) else begin
      errs++; $error("FAIL drain_timeout pending=%0d expected %0d", q.size(), stop_left);
    end
    if (stall_at >= 0) begin
      compared++;
      assert (stalled) else begin
        errs++; $error("FAIL stall_reached stalled=%0d expected 1", stalled);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    compared++;
    assert (bus.in_ready === 1'b1) else begin
      errs++; $error("FAIL %s in_ready=%b expected 1", tag, bus.in_ready);
    end
    compared++;
    assert (bus.out_valid === 1'b0) else begin
      errs++; $error("FAIL %s out_valid=%b expected 0", tag, bus.out_valid);
    end
    compared++;
    assert (bus.out_data === '0) else begin
      errs++; $error("FAIL %s out_data=%h expected 0", tag, bus.out_data);
    end
    compared++;
    assert (bus.out_idx === '0) else begin
      errs++; $error("FAIL %s out_idx=%0d expected 0", tag, bus.out_idx);
    end
  endtask

  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle(tag);
    q.delete();
    acc_cnt        = 0;
    chk_valid_next = 1'b0;
    stalled_prev   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int rv[6];
    int re[6];
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #3;
    check_idle("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send_frame(basic_v, basic_e, 1'b0);
    drain(-1, 0);
    send_frame(tie_v, tie_e, 1'b0);
    drain(-1, 0);
    send_frame(sat_v, sat_e, 1'b0);
    drain(-1, 0);
    send_frame(zero_v, zero_e, 1'b0);
    drain(-1, 0);

    send_frame(basic_v, basic_e, 1'b1);
    drain(2, 0);

    send_inputs(basic_v, 3, 1'b0);
    do_reset("reset_mid_collect");
    send_frame(basic_v, basic_e, 1'b0);
    drain(-1, 0);

    send_frame(basic_v, basic_e, 1'b0);
    drain(-1, 2);
    do_reset("reset_mid_emit");
    send_frame(tie_v, tie_e, 1'b1);
    drain(-1, 0);

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 6; k++)
        rv[k] = ($urandom_range(0, 3) == 0) ? -512 : int'($urandom_range(0, 1023)) - 512;
      model(rv, re);
      send_frame(rv, re, 1'b1);
      drain(int'($urandom_range(0, 5)), 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

endmodule
